// File: rtl/pkg_divider.sv
// Shared types and constants for the restoring divider.
package pkg_divider;

   // Divider control states.
   typedef enum logic [1:0] {
      IDLE,
      CALC,
      DONE
   } state_t;

   // Widest operand the divide-by-zero quotient constant covers.
   localparam int unsigned MAX_WIDTH = 64;

   // Quotient reported for a divide by zero; sliced to the operand width by the user.
   localparam logic [MAX_WIDTH-1:0] DIV_ZERO_Q = '1;

   // Width of an iteration counter that must reach width-1.
   function automatic int unsigned cnt_width(input int unsigned width);
      return (width < 2) ? 1 : $clog2(width);
   endfunction

endpackage

// File: rtl/module_cla_subtractor.sv
// Carry look-ahead subtractor: diff = a - b computed as a + ~b + 1.
module module_cla_subtractor #(
   parameter int unsigned WIDTH = 9
) (
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic [WIDTH-1:0] diff_o,
   output logic             borrow_o
);

   logic [WIDTH-1:0] b_inv;
   logic [WIDTH-1:0] gen;
   logic [WIDTH-1:0] prop;
   logic [WIDTH:0]   carry;

   assign b_inv = ~b_i;
   assign gen   = a_i & b_inv;
   assign prop  = a_i ^ b_inv;

   // Each carry is the flattened look-ahead sum of products, carry-in fixed at 1.
   always_comb begin
      logic acc;
      logic term;
      carry    = '0;
      carry[0] = 1'b1;
      for (int i = 0; i < int'(WIDTH); i++) begin
         term = 1'b1;
         for (int k = 0; k <= i; k++) begin
            term = term & prop[k];
         end
         acc = term;
         for (int j = 0; j <= i; j++) begin
            term = gen[j];
            for (int k = j + 1; k <= i; k++) begin
               term = term & prop[k];
            end
            acc = acc | term;
         end
         carry[i+1] = acc;
      end
   end

   // A missing carry out of a + ~b + 1 means a < b.
   always_comb begin
      diff_o   = prop ^ carry[WIDTH-1:0];
      borrow_o = ~carry[WIDTH];
   end

endmodule

// File: rtl/module_restoring_divider.sv
// Iterative unsigned restoring divider, one quotient bit per clock.
module module_restoring_divider
   import pkg_divider::*;
#(
   parameter int unsigned DIV_WIDTH = 8
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 valid_i,
   output logic                 ready_o,
   input  logic [DIV_WIDTH-1:0] dividend_i,
   input  logic [DIV_WIDTH-1:0] divisor_i,
   output logic                 valid_o,
   input  logic                 ready_i,
   output logic [DIV_WIDTH-1:0] quotient_o,
   output logic [DIV_WIDTH-1:0] remainder_o,
   output logic                 div_by_zero_o
);

   localparam int unsigned CNT_WIDTH = cnt_width(DIV_WIDTH);
   localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(DIV_WIDTH - 1);

   state_t state_q, state_d;

   logic [DIV_WIDTH-1:0] rem_q, quo_q, divisor_q;
   logic [DIV_WIDTH-1:0] rem_next, quo_next;
   logic [DIV_WIDTH-1:0] quotient_q, remainder_q;
   logic                 dbz_q;
   logic [CNT_WIDTH-1:0] cnt_q;
   logic [DIV_WIDTH:0]   rem_shift, trial_diff;
   logic                 trial_borrow;
   logic                 last_iter;
   logic                 unused_diff_msb;

   // Shift the next dividend bit into the partial remainder; one spare bit avoids overflow.
   assign rem_shift = {rem_q, quo_q[DIV_WIDTH-1]};
   assign last_iter = (cnt_q == LAST_CNT);

   module_cla_subtractor #(
      .WIDTH(DIV_WIDTH + 1)
   ) u_trial_sub (
      .a_i     (rem_shift),
      .b_i     ({1'b0, divisor_q}),
      .diff_o  (trial_diff),
      .borrow_o(trial_borrow)
   );

   // A successful trial leaves diff < divisor, so its top bit is always zero.
   assign unused_diff_msb = trial_diff[DIV_WIDTH];

   // Keep the trial difference on success, otherwise restore the shifted remainder.
   always_comb begin
      rem_next = trial_borrow ? rem_shift[DIV_WIDTH-1:0] : trial_diff[DIV_WIDTH-1:0];
      quo_next = {quo_q[DIV_WIDTH-2:0], ~trial_borrow};
   end

   // State register.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (valid_i) begin
               state_d = (divisor_i == '0) ? DONE : CALC;
            end
         end
         CALC: begin
            if (last_iter) begin
               state_d = DONE;
            end
         end
         DONE: begin
            if (ready_i) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Handshake and result outputs, all taken from registers.
   always_comb begin
      ready_o       = (state_q == IDLE);
      valid_o       = (state_q == DONE);
      quotient_o    = quotient_q;
      remainder_o   = remainder_q;
      div_by_zero_o = dbz_q;
   end

   // Datapath: operand capture, one iteration per CALC cycle, result load.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rem_q       <= '0;
         quo_q       <= '0;
         divisor_q   <= '0;
         cnt_q       <= '0;
         quotient_q  <= '0;
         remainder_q <= '0;
         dbz_q       <= 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (valid_i) begin
                  if (divisor_i == '0) begin
                     quotient_q  <= DIV_ZERO_Q[DIV_WIDTH-1:0];
                     remainder_q <= dividend_i;
                     dbz_q       <= 1'b1;
                  end else begin
                     divisor_q <= divisor_i;
                     quo_q     <= dividend_i;
                     rem_q     <= '0;
                     cnt_q     <= '0;
                  end
               end
            end
            CALC: begin
               rem_q <= rem_next;
               quo_q <= quo_next;
               cnt_q <= cnt_q + CNT_WIDTH'(1);
               if (last_iter) begin
                  quotient_q  <= quo_next;
                  remainder_q <= rem_next;
                  dbz_q       <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
